spi_read_target: RTL

SPI mode-0 target (peripheral side) answering the serial-flash READ command (0x03) issued by our SPI flash controller, serving bytes from a 16-bit-wide internal memory bus. Lets one of our chips emulate a boot/data flash for another chip's flash controller, or lets an external host read on-chip memory through the same protocol. Sits between the external SPI pins and a word-wide read port (ROM/RAM arbiter).

---
 rtl/spi_read_target_if.sv | 22 ++
 rtl/spi_read_target.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_read_target_if.sv
// Word-wide read port between the SPI flash-emulation target and a memory arbiter.
// The target is the requester (master); the memory side answers (slave).
interface spi_read_target_if;
    logic [15:0] addr;
    logic        addr_valid;
    logic [15:0] data;
    logic        data_valid;

    modport master (
        output addr,
        output addr_valid,
        input  data,
        input  data_valid
    );

    modport slave (
        input  addr,
        input  addr_valid,
        output data,
        output data_valid
    );
endinterface

// File: rtl/spi_read_target.sv
// SPI mode-0 target answering the serial-flash READ (0x03) command from a 16-bit read port.
// All SPI pins are oversampled by clk_in; bytes stream until chip select rises.
module spi_read_target #(
    parameter int unsigned CLK_RATIO_MIN = 16
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic miso_out,
    output logic miso_oe_out,
    output logic busy_out,
    spi_read_target_if.master bus
);

    // Synchronizer plus registered edge detect needs at least 4 clocks per sclk half period.
    if (CLK_RATIO_MIN < 8) begin : g_ratio_chk
        $error("CLK_RATIO_MIN too small for the pin sampling latency");
    end

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

    localparam logic [7:0] ReadCmd = 8'h03;

    logic [1:0]  rst_sync_q;
    logic        rst_n;
    logic [2:0]  sclk_sync_q;
    logic [2:0]  cs_sync_q;
    logic [1:0]  mosi_sync_q;
    logic        sclk_rise_q;
    logic        sclk_fall_q;
    logic        cs_rise_q;
    logic        cs_fall_q;
    logic        mosi_smp_q;

    state_e      state_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  cmd_q;
    logic [15:0] ptr_q;
    logic [15:0] word_buf_q;
    logic        pending_q;
    logic        first_q;
    logic [2:0]  tx_cnt_q;
    logic [7:0]  tx_shift_q;
    logic        miso_q;
    logic        miso_oe_q;
    logic        busy_q;
    logic [15:0] addr_q;
    logic        addr_valid_q;

    logic [15:0] next_ptr;
    logic [7:0]  next_byte;
    logic [15:0] addr_shift;
    logic [7:0]  cmd_shift;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_smp_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_in};
            cs_sync_q   <= {cs_sync_q[1:0], cs_in};
            mosi_sync_q <= {mosi_sync_q[0], mosi_in};
            sclk_rise_q <= sclk_sync_q[1] & ~sclk_sync_q[2];
            sclk_fall_q <= ~sclk_sync_q[1] & sclk_sync_q[2];
            cs_rise_q   <= cs_sync_q[1] & ~cs_sync_q[2];
            cs_fall_q   <= ~cs_sync_q[1] & cs_sync_q[2];
            // Delayed alongside the edge flags so it lines up with sclk_rise_q.
            mosi_smp_q  <= mosi_sync_q[1];
        end
    end

    always_comb begin
        next_ptr   = first_q ? ptr_q : ptr_q + 16'd1;
        next_byte  = next_ptr[0] ? word_buf_q[7:0] : word_buf_q[15:8];
        addr_shift = {ptr_q[14:0], mosi_smp_q};
        cmd_shift  = {cmd_q[6:0], mosi_smp_q};
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 5'd0;
            cmd_q        <= 8'h00;
            ptr_q        <= 16'h0000;
            word_buf_q   <= 16'h0000;
            pending_q    <= 1'b0;
            first_q      <= 1'b0;
            tx_cnt_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= 16'h0000;
            addr_valid_q <= 1'b0;
        end else begin
            addr_valid_q <= 1'b0;
            if (cs_rise_q) begin
                state_q   <= StIdle;
                bit_cnt_q <= 5'd0;
                tx_cnt_q  <= 3'd0;
                pending_q <= 1'b0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall_q) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= 5'd0;
                        end
                    end
                    StCmd: begin
                        if (sclk_rise_q) begin
                            cmd_q     <= cmd_shift;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= 5'd0;
                                if (cmd_shift == ReadCmd) begin
                                    state_q <= StAddr;
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddr: begin
                        if (sclk_rise_q) begin
                            // Upper address byte simply falls off the top of ptr_q.
                            ptr_q     <= addr_shift;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q    <= 5'd0;
                                addr_q       <= {addr_shift[15:1], 1'b0};
                                addr_valid_q <= 1'b1;
                                pending_q    <= 1'b1;
                                first_q      <= 1'b1;
                                tx_cnt_q     <= 3'd0;
                                miso_oe_q    <= 1'b1;
                                state_q      <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (pending_q && bus.data_valid) begin
                            word_buf_q <= bus.data;
                            pending_q  <= 1'b0;
                        end
                        if (sclk_fall_q) begin
                            tx_cnt_q <= tx_cnt_q + 3'd1;
                            if (tx_cnt_q == 3'd0) begin
                                ptr_q      <= next_ptr;
                                first_q    <= 1'b0;
                                miso_q     <= next_byte[7];
                                tx_shift_q <= {next_byte[6:0], 1'b0};
                                // Odd byte is the last use of this word: fetch the next one now.
                                if (next_ptr[0]) begin
                                    addr_q       <= {next_ptr[15:1] + 15'd1, 1'b0};
                                    addr_valid_q <= 1'b1;
                                    pending_q    <= 1'b1;
                                end
                            end else begin
                                miso_q     <= tx_shift_q[7];
                                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    StIgnore: begin
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign miso_out       = miso_q;
    assign miso_oe_out    = miso_oe_q;
    assign busy_out       = busy_q;
    assign bus.addr       = addr_q;
    assign bus.addr_valid = addr_valid_q;

endmodule
